// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed style transmitter:
// FSM states, SYNC pattern, line-state encodings ({D+, D-}) and NRZI helper.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam int         DEFAULT_CLKS_PER_BIT = 8;
    localparam logic [7:0] SYNC_BYTE            = 8'h80;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // A 0 flips between J and K, a 1 keeps the present level.
    function automatic logic [1:0] nrziNext(input logic [1:0] line, input logic bitVal);
        if (bitVal) begin
            return line;
        end
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream handshake and line/status signals between a packet source
// (master) and the USB transmitter (slave).
interface usb_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, tx_data, tx_data_valid, tx_last,
        input  tx_data_ready, dplus_out, dminus_out, tx_active, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_data, tx_data_valid, tx_last,
        output tx_data_ready, dplus_out, dminus_out, tx_active, tx_done, tx_error
    );

endinterface

// File: rtl/usb_tx_timer.sv
// Bit-time counter plus bit index for the transmitter; produces the
// bit-end strobe and the byte-boundary strobe (stuff bits never end a byte).
module usb_tx_timer import usb_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_stuffBit,
    output logic       o_bitEnd,
    output logic       o_byteEnd,
    output logic [2:0] o_bitIdx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitIdx;
    logic          w_bitEnd;

    assign w_bitEnd = i_run && (r_cnt == CW'(CLKS_PER_BIT - 1));

    // The index stays put across a stuff bit so the data bit after it resumes in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
        end else if (!i_run) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
        end else if (w_bitEnd) begin
            r_cnt <= '0;
            if (!i_stuffBit) begin
                r_bitIdx <= r_bitIdx + 3'd1;
            end
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_bitEnd  = w_bitEnd;
    assign o_byteEnd = w_bitEnd && !i_stuffBit && (r_bitIdx == 3'd7);
    assign o_bitIdx  = r_bitIdx;

endmodule

// File: rtl/usb_tx.sv
// USB packet transmitter: SYNC, LSB-first payload with NRZI and bit stuffing,
// then SE0/SE0/J end-of-packet, driven on registered D+/D- lines.
module usb_tx import usb_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     rst,
    usb_tx_if.slave  bus
);

    tx_state_t  r_state;
    tx_state_t  w_nextState;
    logic [1:0] r_line;
    logic [1:0] w_lineNext;
    logic [7:0] r_byte;
    logic       r_last;
    logic       r_stuff;
    logic       r_eopPend;
    logic [2:0] r_ones;
    logic       r_done;
    logic       r_err;

    logic       w_run;
    logic       w_bitEnd;
    logic       w_byteEnd;
    logic [2:0] w_bitIdx;
    logic [2:0] w_nextIdx;
    logic       w_sending;
    logic       w_accept;
    logic [7:0] w_curByte;
    logic [7:0] w_srcByte;
    logic       w_curBit;
    logic       w_stuffDue;
    logic       w_boundary;
    logic       w_endOfData;
    logic       w_load;
    logic       w_underrun;
    logic       w_goEop;

    assign w_run = (r_state != IDLE);

    usb_tx_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .i_stuffBit (r_stuff),
        .o_bitEnd   (w_bitEnd),
        .o_byteEnd  (w_byteEnd),
        .o_bitIdx   (w_bitIdx)
    );

    assign w_sending   = (r_state == SYNC) || (r_state == DATA);
    assign w_accept    = (r_state == IDLE) && bus.tx_start && !r_done;
    assign w_curByte   = (r_state == SYNC) ? SYNC_BYTE : r_byte;
    assign w_curBit    = w_curByte[w_bitIdx];
    assign w_stuffDue  = w_sending && w_bitEnd && !r_stuff && w_curBit && (r_ones == 3'd5);
    assign w_boundary  = w_sending && w_byteEnd;
    assign w_endOfData = (r_state == DATA) && r_last;
    assign w_load      = w_boundary && !w_endOfData && bus.tx_data_valid;
    assign w_underrun  = w_boundary && !w_endOfData && !bus.tx_data_valid;
    assign w_goEop     = w_boundary && !w_load;
    assign w_nextIdx   = r_stuff ? w_bitIdx : (w_bitIdx + 3'd1);
    assign w_srcByte   = w_load ? bus.tx_data : w_curByte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A stuff bit owed at a byte end delays the move to EOP until it has been sent.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = SYNC;
                end
            end
            SYNC, DATA: begin
                if (w_bitEnd && r_stuff && r_eopPend) begin
                    w_nextState = EOP_SE0;
                end else if (w_load) begin
                    w_nextState = DATA;
                end else if (w_goEop && !w_stuffDue) begin
                    w_nextState = EOP_SE0;
                end
            end
            EOP_SE0: begin
                if (w_bitEnd && (w_bitIdx == 3'd1)) begin
                    w_nextState = EOP_J;
                end
            end
            EOP_J: begin
                if (w_bitEnd) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_lineNext = r_line;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_lineNext = nrziNext(r_line, SYNC_BYTE[0]);
                end
            end
            SYNC, DATA: begin
                if (w_bitEnd) begin
                    if (w_stuffDue) begin
                        w_lineNext = nrziNext(r_line, 1'b0);
                    end else if (w_nextState == EOP_SE0) begin
                        w_lineNext = LINE_SE0;
                    end else begin
                        w_lineNext = nrziNext(r_line, w_srcByte[w_nextIdx]);
                    end
                end
            end
            EOP_SE0: begin
                if (w_nextState == EOP_J) begin
                    w_lineNext = LINE_J;
                end
            end
            default: w_lineNext = r_line;
        endcase
    end

    // The ones-run counts from SYNC onward and clears on any 0, stuffed or real.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line    <= LINE_J;
            r_byte    <= '0;
            r_last    <= 1'b0;
            r_stuff   <= 1'b0;
            r_eopPend <= 1'b0;
            r_ones    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_line <= w_lineNext;
            r_done <= (r_state == EOP_J) && (w_nextState == IDLE);
            if (w_accept) begin
                r_last    <= 1'b0;
                r_stuff   <= 1'b0;
                r_eopPend <= 1'b0;
                r_ones    <= '0;
                r_err     <= 1'b0;
            end else if (w_sending && w_bitEnd) begin
                r_stuff <= w_stuffDue;
                if (r_stuff || !w_curBit) begin
                    r_ones <= '0;
                end else begin
                    r_ones <= r_ones + 3'd1;
                end
                if (w_goEop && w_stuffDue) begin
                    r_eopPend <= 1'b1;
                end
                if (w_underrun) begin
                    r_err <= 1'b1;
                end
            end
            if (w_load) begin
                r_byte <= bus.tx_data;
                r_last <= bus.tx_last;
            end
        end
    end

    assign bus.tx_data_ready = w_load;
    assign bus.dplus_out     = r_line[1];
    assign bus.dminus_out    = r_line[0];
    assign bus.tx_active     = w_run;
    assign bus.tx_done       = r_done;
    assign bus.tx_error      = r_err;

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: stimulus queues hand-derived per-clock line levels,
// ready cycles and done records; a negedge monitor pops and compares them.
module tb_usb_tx;
    import usb_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst;

    usb_tx_if bus();

    usb_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   len;
        logic err;
    } done_t;

    int         nCompared   = 0;
    int         nMismatched = 0;
    int         activeCycle = 0;
    logic [1:0] lineQ[$];
    int         readyQ[$];
    done_t      doneQ[$];
    done_t      monDone;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Each character is one bit time: K, J, or S for SE0.
    task automatic pushLine(input string bits);
        logic [1:0] lvl;
        for (int i = 0; i < bits.len(); i++) begin
            if (bits[i] == "K")      lvl = LINE_K;
            else if (bits[i] == "J") lvl = LINE_J;
            else                     lvl = LINE_SE0;
            for (int c = 0; c < CPB; c++) lineQ.push_back(lvl);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            activeCycle = 0;
        end else begin
            if (bus.tx_active) begin
                activeCycle++;
                if (lineQ.size() == 0)
                    checkOutput($sformatf("unexpected activity cycle %0d", activeCycle), 1, 0);
                else
                    checkOutput($sformatf("line cycle %0d", activeCycle),
                                int'({bus.dplus_out, bus.dminus_out}), int'(lineQ.pop_front()));
            end
            if (bus.tx_data_ready) begin
                if (readyQ.size() == 0)
                    checkOutput("unexpected tx_data_ready", 1, 0);
                else
                    checkOutput("tx_data_ready cycle", activeCycle, readyQ.pop_front());
            end
            if (bus.tx_done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected tx_done", 1, 0);
                end else begin
                    monDone = doneQ.pop_front();
                    checkOutput("clocks until tx_done", activeCycle, monDone.len);
                    checkOutput("tx_error at done", int'(bus.tx_error), int'(monDone.err));
                end
            end
            if (!bus.tx_active) activeCycle = 0;
        end
    end

    task automatic applyStimulus(input int nBytes, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic lastFlag, input string dataLine,
                                 input int rdy0, input int rdy1, input int expLen,
                                 input logic expErr, input logic pokeStart);
        done_t d;
        int    sent;
        int    cyc;
        logic  doneSeen;
        pushLine({"KJKJKJKK", dataLine, "SSJ"});
        if (rdy0 > 0) readyQ.push_back(rdy0);
        if (rdy1 > 0) readyQ.push_back(rdy1);
        d.len = expLen;
        d.err = expErr;
        doneQ.push_back(d);

        @(negedge clk);
        bus.tx_start      = 1'b1;
        bus.tx_data_valid = 1'b0;
        bus.tx_data       = b0;
        bus.tx_last       = (nBytes == 1) ? lastFlag : 1'b0;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        checkOutput("tx_error cleared by start", int'(bus.tx_error), 0);
        repeat (10) @(posedge clk);
        #1 bus.tx_data_valid = 1'b1;

        sent = 0;
        cyc  = 0;
        while (sent < nBytes && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.tx_start = pokeStart && (cyc == 30);
            if (bus.tx_data_ready) begin
                sent++;
                @(posedge clk); #1;
                if (sent < nBytes) begin
                    bus.tx_data = b1;
                    bus.tx_last = lastFlag;
                end else begin
                    bus.tx_data_valid = 1'b0;
                end
            end
        end
        bus.tx_start      = 1'b0;
        bus.tx_data_valid = 1'b0;
        checkOutput("bytes accepted", sent, nBytes);

        doneSeen = 1'b0;
        cyc      = 0;
        while (!doneSeen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.tx_done) doneSeen = 1'b1;
        end
        #1;
        checkOutput("tx_done seen", int'(doneSeen), 1);
        checkOutput("line entries left", lineQ.size(), 0);
        checkOutput("ready entries left", readyQ.size(), 0);
        checkOutput("done entries left", doneQ.size(), 0);
        lineQ.delete();
        readyQ.delete();
        doneQ.delete();
    endtask

    task automatic resetMidPacket();
        for (int i = 0; i < 29; i++) lineQ.push_back(((i / CPB) % 2 == 0) ? LINE_K : LINE_J);
        @(negedge clk);
        bus.tx_start      = 1'b1;
        bus.tx_data_valid = 1'b0;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        repeat (29) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("line during reset", int'({bus.dplus_out, bus.dminus_out}), int'(LINE_J));
        checkOutput("tx_active during reset", int'(bus.tx_active), 0);
        checkOutput("tx_done during reset", int'(bus.tx_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        checkOutput("line entries left after reset", lineQ.size(), 0);
        lineQ.delete();
    endtask

    initial begin
        rst               = 1'b1;
        bus.tx_start      = 1'b0;
        bus.tx_data       = 8'h00;
        bus.tx_data_valid = 1'b0;
        bus.tx_last       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle D+", int'(bus.dplus_out), 1);
        checkOutput("idle D-", int'(bus.dminus_out), 0);
        checkOutput("idle tx_active", int'(bus.tx_active), 0);
        checkOutput("idle tx_done", int'(bus.tx_done), 0);
        checkOutput("idle tx_data_ready", int'(bus.tx_data_ready), 0);
        checkOutput("idle tx_error", int'(bus.tx_error), 0);

        $display("[TB] single byte 0x00");
        applyStimulus(1, 8'h00, 8'h00, 1'b1, "JKJKJKJK", 64, 0, 152, 1'b0, 1'b0);

        bus.tx_start = 1'b1;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("start during done ignored", int'(bus.tx_active), 0);

        $display("[TB] single byte 0xFF with stuff bit");
        applyStimulus(1, 8'hFF, 8'h00, 1'b1, "KKKKKJJJJ", 64, 0, 160, 1'b0, 1'b1);

        $display("[TB] two bytes 0xA5 0x3C");
        applyStimulus(2, 8'hA5, 8'h3C, 1'b1, "KJJKJJKKJKKKKKJK", 64, 128, 216, 1'b0, 1'b0);

        $display("[TB] underrun after 0x81");
        applyStimulus(1, 8'h81, 8'h00, 1'b0, "KJKJKJKK", 64, 0, 152, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("tx_error held in idle", int'(bus.tx_error), 1);

        $display("[TB] packet after underrun");
        applyStimulus(1, 8'h00, 8'h00, 1'b1, "JKJKJKJK", 64, 0, 152, 1'b0, 1'b0);

        $display("[TB] reset during SYNC");
        resetMidPacket();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
